// File: rtl/primitive_query_responder.sv
// Responder for primitive range queries: reads [start,end) from a synchronous RAM
// one word per cycle and returns lane groups of UNIT_SIZE with a mask and last flag.
module primitive_query_responder #(
   parameter int unsigned PRIM_WIDTH  = 256,
   parameter int unsigned INDEX_WIDTH = 10,
   parameter int unsigned UNIT_SIZE   = 2
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            query_valid,
   output logic                            query_ready,
   input  logic [INDEX_WIDTH-1:0]          query_start,
   input  logic [INDEX_WIDTH-1:0]          query_end,
   input  logic                            abort,
   output logic                            mem_rd,
   output logic [INDEX_WIDTH-1:0]          mem_addr,
   input  logic [PRIM_WIDTH-1:0]           mem_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [UNIT_SIZE*PRIM_WIDTH-1:0] out_prim,
   output logic [UNIT_SIZE-1:0]            out_mask,
   output logic                            out_last
);

   localparam int unsigned CW = $clog2(UNIT_SIZE + 1);
   localparam logic [CW-1:0] LANES = CW'(UNIT_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_EMIT} state_t;

   state_t                          state_q, state_d;
   logic [INDEX_WIDTH-1:0]          cur_q, cur_d;
   logic [INDEX_WIDTH-1:0]          end_q, end_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic                            rd_pend_q, rd_pend_d;
   logic [UNIT_SIZE*PRIM_WIDTH-1:0] prim_q, prim_d;
   logic [UNIT_SIZE-1:0]            mask_q, mask_d;
   logic                            last_q, last_d;
   logic                            valid_q, valid_d;

   assign query_ready = (state_q == S_IDLE);
   assign mem_rd      = (state_q == S_READ);
   assign mem_addr    = cur_q;
   assign out_valid   = valid_q;
   assign out_prim    = prim_q;
   assign out_mask    = mask_q;
   assign out_last    = last_q;

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      end_d     = end_q;
      cnt_d     = cnt_q;
      rd_pend_d = 1'b0;
      prim_d    = prim_q;
      mask_d    = mask_q;
      last_d    = last_q;
      valid_d   = valid_q;

      // cnt_q already counts the read whose data arrives now, so its lane is cnt_q-1
      if (rd_pend_q) begin
         for (int unsigned i = 0; i < UNIT_SIZE; i++) begin
            if (CW'(i) == cnt_q - CW'(1)) begin
               prim_d[i*PRIM_WIDTH +: PRIM_WIDTH] = mem_data;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (query_valid) begin
               cur_d = query_start;
               end_d = query_end;
               cnt_d = '0;
               if (query_start >= query_end) begin
                  state_d = S_EMIT;
                  valid_d = 1'b1;
                  mask_d  = '0;
                  last_d  = 1'b1;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            rd_pend_d = 1'b1;
            cur_d     = cur_q + INDEX_WIDTH'(1);
            cnt_d     = cnt_q + CW'(1);
            if ((cnt_q + CW'(1) == LANES) || (cur_q + INDEX_WIDTH'(1) == end_q)) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            state_d = S_EMIT;
            valid_d = 1'b1;
            last_d  = (cur_q == end_q);
            for (int unsigned i = 0; i < UNIT_SIZE; i++) begin
               mask_d[i] = (CW'(i) < cnt_q);
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_READ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort discards everything computed above, including any word in flight
      if (abort) begin
         state_d   = S_IDLE;
         cur_d     = cur_q;
         end_d     = end_q;
         cnt_d     = cnt_q;
         rd_pend_d = 1'b0;
         prim_d    = prim_q;
         mask_d    = mask_q;
         last_d    = last_q;
         valid_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cur_q     <= '0;
         end_q     <= '0;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         prim_q    <= '0;
         mask_q    <= '0;
         last_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         end_q     <= end_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         prim_q    <= prim_d;
         mask_q    <= mask_d;
         last_q    <= last_d;
         valid_q   <= valid_d;
      end
   end

endmodule
